// File: rtl/riscv_ex_muldiv.sv
// rtl/riscv_ex_muldiv.sv - iterative RISC-V M-extension multiply/divide execute unit
module riscv_ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            id_ex_rdy,
    output logic            id_ex_ack,
    input  logic [2:0]      id_ex_funct,
    input  logic [XLEN-1:0] id_ex_op1,
    input  logic [XLEN-1:0] id_ex_op2,
    input  logic [4:0]      id_ex_wb_rsd,
    output logic            ex_mem_rdy,
    input  logic            ex_mem_ack,
    output logic [XLEN-1:0] ex_mem_result,
    output logic [4:0]      ex_mem_wb_rsd
);
    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0]   LAST    = CW'(STEPS - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      funct;
    logic [4:0]      rsd;
    logic            neg;
    logic [XLEN:0]   hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] b;

    assign id_ex_ack = (state == IDLE);

    // Operand decode: signedness, magnitudes and the one-cycle special cases.
    logic            s1, s2, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2, spec_res;

    always_comb begin
        s1 = id_ex_op1[XLEN-1] && (id_ex_funct != 3'd3) && !(id_ex_funct[2] && id_ex_funct[0]);
        s2 = id_ex_op2[XLEN-1] && (id_ex_funct[2:1] != 2'b01) && !(id_ex_funct[2] && id_ex_funct[0]);
        mag1 = s1 ? -id_ex_op1 : id_ex_op1;
        mag2 = s2 ? -id_ex_op2 : id_ex_op2;
        div_zero = id_ex_funct[2] && (id_ex_op2 == '0);
        div_ovf  = id_ex_funct[2] && !id_ex_funct[0] && (id_ex_op1 == MIN_NEG) && (id_ex_op2 == '1);
        if (id_ex_funct[1])
            spec_res = div_zero ? id_ex_op1 : '0;
        else
            spec_res = div_zero ? '1 : id_ex_op1;
    end

    // One iteration: UNROLL shift-add or restoring-subtract steps.
    logic [XLEN:0]   hi_nx, trial;
    logic [XLEN-1:0] lo_nx;

    always_comb begin
        hi_nx = hi;
        lo_nx = lo;
        trial = '0;
        for (int u = 0; u < UNROLL; u++) begin
            if (funct[2]) begin
                trial = {hi_nx[XLEN-1:0], lo_nx[XLEN-1]};
                lo_nx = {lo_nx[XLEN-2:0], 1'b0};
                if (trial >= {1'b0, b}) begin
                    hi_nx    = trial - {1'b0, b};
                    lo_nx[0] = 1'b1;
                end else begin
                    hi_nx = trial;
                end
            end else begin
                if (lo_nx[0])
                    hi_nx = {1'b0, hi_nx[XLEN-1:0]} + {1'b0, b};
                {hi_nx, lo_nx} = {1'b0, hi_nx, lo_nx[XLEN-1:1]};
            end
        end
    end

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   res;

    always_comb begin
        prod   = {hi_nx[XLEN-1:0], lo_nx};
        prod_s = neg ? -prod : prod;
        case (funct)
            3'd0:          res = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    res = neg ? -lo_nx : lo_nx;
            default:       res = neg ? -hi_nx[XLEN-1:0] : hi_nx[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            count         <= '0;
            funct         <= '0;
            rsd           <= '0;
            neg           <= 1'b0;
            hi            <= '0;
            lo            <= '0;
            b             <= '0;
            ex_mem_rdy    <= 1'b0;
            ex_mem_result <= '0;
            ex_mem_wb_rsd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (id_ex_rdy) begin
                        funct <= id_ex_funct;
                        rsd   <= id_ex_wb_rsd;
                        count <= '0;
                        hi    <= '0;
                        lo    <= id_ex_funct[2] ? mag1 : mag2;
                        b     <= id_ex_funct[2] ? mag2 : mag1;
                        neg   <= (id_ex_funct == 3'd6) ? s1 : (s1 ^ s2);
                        if (div_zero || div_ovf) begin
                            // Result is known now; DONE raises rdy on the following edge.
                            ex_mem_result <= spec_res;
                            ex_mem_wb_rsd <= id_ex_wb_rsd;
                            state         <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi    <= hi_nx;
                    lo    <= lo_nx;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        ex_mem_result <= res;
                        ex_mem_wb_rsd <= rsd;
                        ex_mem_rdy    <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (ex_mem_rdy) begin
                        if (ex_mem_ack) begin
                            ex_mem_rdy <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        ex_mem_rdy <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/riscv_ex_muldiv.md
# riscv_ex_muldiv

Parametrised iterative multiply/divide execute unit implementing the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle integer ALU in the execute stage, takes decoded operands from ID over the rdy/ack handshake, and delivers results to MEM over the same handshake. Unlike the ALU it is multi-cycle, so it can stall. It generalises XLEN and the bits retired per iteration.

## Interface
- XLEN, 32: operand/result width; even, >= 8.
- UNROLL, 1: bits processed per iteration; must divide XLEN (1, 2 or 4).
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- id_ex_rdy  in  1  ID presents a valid operation.
- id_ex_ack  out  1  unit accepts the operation this cycle.
- id_ex_funct  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- id_ex_op1  in  XLEN  rs1 value (multiplicand/dividend).
- id_ex_op2  in  XLEN  rs2 value (multiplier/divisor).
- id_ex_wb_rsd  in  5  destination register, passed through.
- ex_mem_rdy  out  1  result valid toward MEM.
- ex_mem_ack  in  1  MEM consumes the result.
- ex_mem_result  out  XLEN  result.
- ex_mem_wb_rsd  out  5  destination register of the result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: id_ex_ack = 1 (combinational, state only). On id_ex_rdy, latch funct, wb_rsd, operand magnitudes and the result sign. Go to CALC, count = 0. Special cases go straight to DONE (see below).
- CALC: id_ex_ack = 0. Each cycle processes UNROLL bits and increments count. At count = XLEN/UNROLL − 1, apply sign correction, register ex_mem_result and go to DONE.
- DONE: ex_mem_rdy = 1 and outputs stay stable. On ex_mem_ack, go to IDLE. id_ex_ack = 0 in DONE.
- Multiply:
  - Unsigned shift-add into a 2·XLEN product.
  - Signed operands (MUL/MULH: both; MULHSU: op1 only) are converted to magnitude and the product is negated when signs differ.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2·XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes.
  - Quotient is negative when signs differ (DIV). Remainder takes the sign of the dividend (REM).
  - DIVU/REMU are unsigned.
- Special cases, detected in IDLE, 1-cycle path, no CALC:
  - Divide by zero: DIV/DIVU → all-ones; REM/REMU → op1.
  - Signed overflow (op1 = 1 followed by XLEN−1 zeros, op2 = all-ones) for DIV → op1; REM → 0.
- Only one operation is in flight; no pipelining of the datapath.

## Timing
- Reset values: state IDLE, ex_mem_rdy 0, ex_mem_result 0, ex_mem_wb_rsd 0, internal accumulators 0. id_ex_ack is 1 once out of reset.
- Normal latency: acceptance at edge E0; ex_mem_rdy rises after edge E0 + XLEN/UNROLL. For XLEN=32, UNROLL=1 that is 32 cycles; for UNROLL=4 it is 8 cycles.
- Special-case latency: ex_mem_rdy rises after edge E0 + 1.
- Back-pressure: ex_mem_rdy held with result/wb_rsd stable for any number of cycles until ex_mem_ack.
- Throughput: after ack in DONE, one IDLE cycle precedes the next acceptance. Maximum one operation per XLEN/UNROLL + 2 cycles.
- id_ex_rdy while in CALC/DONE is ignored and not acknowledged; ID must hold its inputs.
- ex_mem_ack while ex_mem_rdy = 0 is ignored.
- Async reset mid-CALC or mid-DONE aborts the operation: no result is emitted, and the unit is in IDLE on the first edge after release.

## Test plan
- MUL op1=7, op2=0xFFFFFFFD (−3) → ex_mem_result 0xFFFFFFEB, ex_mem_rdy rises 32 cycles after the accept edge (XLEN=32, UNROLL=1).
- MULH op1=op2=0x80000000 → 0x40000000. MULHU 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 (0xFFFFFFF9) by 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 1.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Each with ex_mem_rdy one cycle after accept.
- Back-pressure: hold ex_mem_ack=0 for 10 cycles in DONE → result/wb_rsd stable, id_ex_ack=0 throughout. Ack → IDLE, and the next op is accepted one cycle later.
- Reset asserted at count 10 of a DIV → ex_mem_rdy 0, outputs 0. After release, a new MUL 3·4 → 12 with correct latency. Repeat all of the above with UNROLL=4 (8-cycle latency) and XLEN=64.
